// File: rtl/bcd_serial_sub_ctrl.sv
// bcd_serial_sub_ctrl
//   Digit-serial packed-BCD subtractor controller. One BCD digit is subtracted
//   per clock, LSD first, with the borrow carried between digits. A negative
//   result is turned into its magnitude by a second digit-serial pass that
//   forms the 10^DIGITS complement of the working result.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - request, sampled only while idle
//   a, b  - minuend / subtrahend, packed BCD, digit 0 in bits [3:0]
//   busy  - high from the cycle after start is accepted through the done cycle
//   done  - one-cycle completion pulse
//   diff  - |a-b| in packed BCD, held until the next completion or reset
//   neg   - 1 when a<b
//   err   - 1 when any digit of a or b exceeds 9
module bcd_serial_sub_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] diff,
    output logic                neg,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [2:0] {IDLE, CHECK, SUB, COMP, DONE} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic            borrow, borrow_nx;
    logic [W-1:0]    ra, rb, rw, ra_nx, rb_nx, rw_nx;
    logic            neg_flag, neg_flag_nx;
    logic            load_out, err_ld;
    logic [IW+1:0]   bit_pos;
    logic [3:0]      x_dig, y_dig, d_res;
    logic [4:0]      t;
    logic            b_out;
    logic            bad_digit;

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign bit_pos = {idx, 2'b00};

    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (ra[4*i +: 4] > 4'd9 || rb[4*i +: 4] > 4'd9)
                bad_digit = 1'b1;
        end
    end

    // Shared one-digit subtract: SUB uses ra-rb, COMP uses 0-rw.
    always_comb begin
        if (state == COMP) begin
            x_dig = 4'd0;
            y_dig = rw[bit_pos +: 4];
        end else begin
            x_dig = ra[bit_pos +: 4];
            y_dig = rb[bit_pos +: 4];
        end
        t     = {1'b0, x_dig} - {1'b0, y_dig} - {4'd0, borrow};
        b_out = t[4];
        d_res = b_out ? (t[3:0] + 4'd10) : t[3:0];
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        borrow_nx   = borrow;
        ra_nx       = ra;
        rb_nx       = rb;
        rw_nx       = rw;
        neg_flag_nx = neg_flag;
        load_out    = 1'b0;
        err_ld      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ra_nx       = a;
                    rb_nx       = b;
                    idx_nx      = '0;
                    borrow_nx   = 1'b0;
                    rw_nx       = '0;
                    neg_flag_nx = 1'b0;
                    state_nx    = CHECK;
                end
            end
            CHECK: begin
                if (bad_digit) begin
                    rw_nx       = '0;
                    neg_flag_nx = 1'b0;
                    err_ld      = 1'b1;
                    load_out    = 1'b1;
                    state_nx    = DONE;
                end else begin
                    state_nx = SUB;
                end
            end
            SUB, COMP: begin
                rw_nx[bit_pos +: 4] = d_res;
                borrow_nx           = b_out;
                idx_nx              = idx + 1'b1;
                if (idx == LAST) begin
                    idx_nx    = '0;
                    borrow_nx = 1'b0;
                    if (state == SUB && b_out) begin
                        neg_flag_nx = 1'b1;
                        state_nx    = COMP;
                    end else begin
                        // Complement pass ignores its final borrow.
                        if (state == SUB)
                            neg_flag_nx = 1'b0;
                        load_out = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            borrow   <= 1'b0;
            ra       <= '0;
            rb       <= '0;
            rw       <= '0;
            neg_flag <= 1'b0;
            diff     <= '0;
            neg      <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            borrow   <= borrow_nx;
            ra       <= ra_nx;
            rb       <= rb_nx;
            rw       <= rw_nx;
            neg_flag <= neg_flag_nx;
            // Results are loaded on entry to DONE so they are visible in it.
            if (load_out) begin
                diff <= rw_nx;
                neg  <= neg_flag_nx;
                err  <= err_ld;
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_sub_ctrl.sv
module tb_bcd_serial_sub_ctrl;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [15:0]   a, b;
    logic          busy, done, neg, err;
    logic [15:0]   diff;

    int ncmp  = 0;
    int nfail = 0;

    bcd_serial_sub_ctrl #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .neg(neg), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [15:0] v);
        for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Issue one request and check result, latency, busy span and single done.
    // hammer=1 keeps start asserted for the whole operation.
    task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb_v, input bit hammer);
        int ia, ib, lat, k;
        logic [15:0] ediff;
        bit eneg, eerr, busy_ok, got;
        eerr = has_bad(ta) || has_bad(tb_v);
        ia = bcd2int(ta);
        ib = bcd2int(tb_v);
        if (eerr) begin
            ediff = '0; eneg = 1'b0; lat = 2;
        end else begin
            eneg  = (ia < ib);
            ediff = int2bcd(eneg ? ib - ia : ia - ib);
            lat   = eneg ? 2 + 2 * D : 2 + D;
        end
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        busy_ok = 1'b1; got = 1'b0; k = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (!hammer) start = 1'b0;
            else begin a = rand_bcd(); b = rand_bcd(); end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        chk({tag, ".done_seen"}, 32'(got), 32'd1);
        chk({tag, ".latency"}, 32'(k), 32'(lat));
        chk({tag, ".busy_span"}, 32'(busy_ok), 32'd1);
        chk({tag, ".diff"}, 32'(diff), 32'(ediff));
        chk({tag, ".neg"}, 32'(neg), 32'(eneg));
        chk({tag, ".err"}, 32'(err), 32'(eerr));
        @(negedge clk);
        chk({tag, ".done_pulse"}, {30'd0, done, busy}, 32'd0);
        chk({tag, ".hold"}, {14'd0, err, neg, diff}, {14'd0, eerr, eneg, ediff});
    endtask

    initial begin
        int k;
        bit seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset.outs", {12'd0, busy, done, neg, err, diff}, 32'd0);
        rst = 1'b0;

        run("pos",    16'h5432, 16'h1234, 1'b0);
        run("negv",   16'h1234, 16'h5432, 1'b0);
        run("neg1",   16'h0000, 16'h0001, 1'b0);
        run("zero",   16'h9999, 16'h9999, 1'b0);
        run("ripple", 16'h1000, 16'h0001, 1'b0);
        run("bad",    16'h12A4, 16'h0001, 1'b0);
        run("clrerr", 16'h0042, 16'h0017, 1'b0);
        run("badb",   16'h0001, 16'hF000, 1'b0);
        run("hammer", 16'h0100, 16'h0999, 1'b1);

        for (int i = 0; i < 25; i++) begin
            logic [15:0] ra, rb;
            ra = rand_bcd(); rb = rand_bcd();
            if (i % 8 == 7) ra[4*(i % D) +: 4] = 4'($urandom_range(10, 15));
            run("rand", ra, rb, 1'b0);
        end

        // Reset in the middle of the complement pass.
        @(negedge clk);
        a = 16'h0123; b = 16'h4567; start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("rst_comp.outs", {12'd0, busy, done, neg, err, diff}, 32'd0);
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("rst_comp.no_done", 32'(seen), 32'd0);
        chk("rst_start.not_taken", 32'(busy), 32'd0);
        run("after_rst", 16'h0500, 16'h0250, 1'b0);

        k = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
